car_wipe_acc: RTL and testbench

- Carrier wipe-off and integrate-and-dump stage, directly downstream of the carrier NCO.
- Mixes each signed IF sample with the NCO's cos/sin outputs: I = if·cos, Q = −if·sin.
- Accumulates I/Q over a programmable number of valid samples and emits one dump per period to the tracking/loop-filter logic.

---
 rtl/car_wipe_pkg.sv | 21 ++
 rtl/car_wipe_mult.sv | 48 ++++
 rtl/car_wipe_acc.sv | 193 +++++++++++++++++++
 tb/tb_car_wipe_acc.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/car_wipe_pkg.sv
// Shared types and helpers for the carrier wipe-off / integrate-and-dump slice.
// The saturation helpers are only referenced when CAR_WIPE_SAT_EN is defined.
package car_wipe_pkg;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

  localparam int SAT_CONST_W = 64;

  function automatic int prod_width(input int if_w, input int car_w);
    return if_w + car_w;
  endfunction

  function automatic logic signed [SAT_CONST_W-1:0] sat_max(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [SAT_CONST_W-1:0] sat_min(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

endpackage

// File: rtl/car_wipe_mult.sv
// One channel of the wipe-off mixer: registered signed IF x carrier product,
// optionally negated (Q channel).
module car_wipe_mult
  import car_wipe_pkg::*;
#(
  parameter int IF_WIDTH  = 4,
  parameter int CAR_WIDTH = 8,
  parameter bit NEGATE    = 1'b0,
  localparam int PROD_W   = prod_width(IF_WIDTH, CAR_WIDTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_vld,
  input  logic [IF_WIDTH-1:0]  in_if,
  input  logic [CAR_WIDTH-1:0] in_car,
  output logic [PROD_W-1:0] out_prod,
  output logic              out_vld
);

  logic signed [IF_WIDTH-1:0]  if_s;
  logic signed [CAR_WIDTH-1:0] car_s;
  logic signed [PROD_W-1:0]    prod_raw;
  logic signed [PROD_W-1:0]    prod_p1_d;
  logic signed [PROD_W-1:0]    prod_p1_q;
  logic                        vld_p1_q;

  always_comb begin
    if_s      = in_if;
    car_s     = in_car;
    prod_raw  = PROD_W'(if_s) * PROD_W'(car_s);
    // Full-width product magnitude never reaches 2^(PROD_W-1), so negation is safe.
    prod_p1_d = NEGATE ? -prod_raw : prod_raw;
  end

  // stage 1: product register
  always_ff @(posedge clk) begin
    if (rst) vld_p1_q <= 1'b0;
    else     vld_p1_q <= in_vld;
  end

  always_ff @(posedge clk) begin
    if (in_vld) prod_p1_q <= prod_p1_d;
  end

  assign out_prod = prod_p1_q;
  assign out_vld  = vld_p1_q;

endmodule

// File: rtl/car_wipe_acc.sv
// Carrier wipe-off and integrate-and-dump: I = if*cos, Q = -if*sin, summed over
// rx_dump_len valid samples. Define CAR_WIPE_SAT_EN for saturating accumulators + tx_sat_flag.
module car_wipe_acc
  import car_wipe_pkg::*;
#(
  parameter int CAR_WIDTH      = 8,
  parameter int IF_WIDTH       = 4,
  parameter int ACC_OUT_WIDTH  = 24,
  parameter int DUMP_CNT_WIDTH = 16
) (
  input  logic                      rx_clk,
  input  logic                      rx_rst,
  input  logic                      rx_en,
  input  logic [DUMP_CNT_WIDTH-1:0] rx_dump_len,
  input  logic [IF_WIDTH-1:0]       rx_if,
  input  logic                      rx_if_vld,
  input  logic [CAR_WIDTH-1:0]      rx_car_cos,
  input  logic [CAR_WIDTH-1:0]      rx_car_sin,
  output logic [ACC_OUT_WIDTH-1:0]  tx_i_acc,
  output logic [ACC_OUT_WIDTH-1:0]  tx_q_acc,
`ifdef CAR_WIPE_SAT_EN
  output logic                      tx_sat_flag,
`endif
  output logic                      tx_dump_vld
);

  localparam int PROD_W = prod_width(IF_WIDTH, CAR_WIDTH);

  logic [PROD_W-1:0] prod_i_p1, prod_q_p1;
  logic              vld_i_p1, vld_q_p1, vld_p1;

  car_wipe_mult #(.IF_WIDTH(IF_WIDTH), .CAR_WIDTH(CAR_WIDTH), .NEGATE(1'b0)) u_mult_i (
    .clk(rx_clk), .rst(rx_rst), .in_vld(rx_if_vld & rx_en), .in_if(rx_if),
    .in_car(rx_car_cos), .out_prod(prod_i_p1), .out_vld(vld_i_p1)
  );

  car_wipe_mult #(.IF_WIDTH(IF_WIDTH), .CAR_WIDTH(CAR_WIDTH), .NEGATE(1'b1)) u_mult_q (
    .clk(rx_clk), .rst(rx_rst), .in_vld(rx_if_vld & rx_en), .in_if(rx_if),
    .in_car(rx_car_sin), .out_prod(prod_q_p1), .out_vld(vld_q_p1)
  );

  assign vld_p1 = vld_i_p1 & vld_q_p1;

  state_e                           state_q, state_d;
  logic signed [ACC_OUT_WIDTH-1:0]  acc_i_q, acc_i_d, acc_q_q, acc_q_d;
  logic signed [ACC_OUT_WIDTH-1:0]  tx_i_q, tx_i_d, tx_q_q, tx_q_d;
  logic signed [ACC_OUT_WIDTH-1:0]  ext_i, ext_q, sum_i, sum_q;
  logic [DUMP_CNT_WIDTH-1:0]        cnt_q, cnt_d, len_q, len_d, len_eff;
  logic                             tx_vld_q, tx_vld_d, last_smp;

`ifdef CAR_WIPE_SAT_EN
  localparam logic signed [ACC_OUT_WIDTH-1:0] SAT_MAX = ACC_OUT_WIDTH'(sat_max(ACC_OUT_WIDTH));
  localparam logic signed [ACC_OUT_WIDTH-1:0] SAT_MIN = ACC_OUT_WIDTH'(sat_min(ACC_OUT_WIDTH));

  logic sat_i_q, sat_i_d, sat_q_q, sat_q_d, tx_sat_q, tx_sat_d;
  logic ovf_i, ovf_q, sat_i_nxt, sat_q_nxt;
  logic signed [ACC_OUT_WIDTH-1:0] add_i, add_q;

  // Returns {clamped, value}; overflow shows as disagreeing top two bits of the wide sum.
  function automatic logic [ACC_OUT_WIDTH:0] sat_add(input logic signed [ACC_OUT_WIDTH-1:0] a,
                                                     input logic signed [ACC_OUT_WIDTH-1:0] b);
    logic signed [ACC_OUT_WIDTH:0] s;
    s = {a[ACC_OUT_WIDTH-1], a} + {b[ACC_OUT_WIDTH-1], b};
    if (s[ACC_OUT_WIDTH] != s[ACC_OUT_WIDTH-1])
      return {1'b1, s[ACC_OUT_WIDTH] ? SAT_MIN : SAT_MAX};
    return {1'b0, s[ACC_OUT_WIDTH-1:0]};
  endfunction
`endif

  always_comb begin
    ext_i    = ACC_OUT_WIDTH'(signed'(prod_i_p1));
    ext_q    = ACC_OUT_WIDTH'(signed'(prod_q_p1));
    len_eff  = (len_q == '0) ? DUMP_CNT_WIDTH'(1) : len_q;
    last_smp = (cnt_q + DUMP_CNT_WIDTH'(1)) == len_eff;
`ifdef CAR_WIPE_SAT_EN
    {ovf_i, add_i} = sat_add(acc_i_q, ext_i);
    {ovf_q, add_q} = sat_add(acc_q_q, ext_q);
    // A clamped channel holds its rail until the period ends.
    sum_i     = sat_i_q ? acc_i_q : add_i;
    sum_q     = sat_q_q ? acc_q_q : add_q;
    sat_i_nxt = sat_i_q | ovf_i;
    sat_q_nxt = sat_q_q | ovf_q;
`else
    sum_i = acc_i_q + ext_i;
    sum_q = acc_q_q + ext_q;
`endif

    state_d  = state_q;
    acc_i_d  = acc_i_q;
    acc_q_d  = acc_q_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    tx_i_d   = tx_i_q;
    tx_q_d   = tx_q_q;
    tx_vld_d = 1'b0;
`ifdef CAR_WIPE_SAT_EN
    sat_i_d  = sat_i_q;
    sat_q_d  = sat_q_q;
    tx_sat_d = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        acc_i_d = '0;
        acc_q_d = '0;
        cnt_d   = '0;
        len_d   = rx_dump_len;
`ifdef CAR_WIPE_SAT_EN
        sat_i_d = 1'b0;
        sat_q_d = 1'b0;
`endif
        if (rx_en) state_d = RUN;
      end
      RUN: begin
        if (!rx_en) begin
          state_d = IDLE;
          acc_i_d = '0;
          acc_q_d = '0;
          cnt_d   = '0;
`ifdef CAR_WIPE_SAT_EN
          sat_i_d = 1'b0;
          sat_q_d = 1'b0;
`endif
        end else if (vld_p1) begin
          if (last_smp) begin
            tx_i_d   = sum_i;
            tx_q_d   = sum_q;
            tx_vld_d = 1'b1;
            acc_i_d  = '0;
            acc_q_d  = '0;
            cnt_d    = '0;
            len_d    = rx_dump_len;
`ifdef CAR_WIPE_SAT_EN
            tx_sat_d = sat_i_nxt | sat_q_nxt;
            sat_i_d  = 1'b0;
            sat_q_d  = 1'b0;
`endif
          end else begin
            acc_i_d = sum_i;
            acc_q_d = sum_q;
            cnt_d   = cnt_q + DUMP_CNT_WIDTH'(1);
`ifdef CAR_WIPE_SAT_EN
            sat_i_d = sat_i_nxt;
            sat_q_d = sat_q_nxt;
`endif
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // stage 2: accumulate / dump
  always_ff @(posedge rx_clk) begin
    if (rx_rst) begin
      state_q  <= IDLE;
      acc_i_q  <= '0;
      acc_q_q  <= '0;
      cnt_q    <= '0;
      len_q    <= '0;
      tx_i_q   <= '0;
      tx_q_q   <= '0;
      tx_vld_q <= 1'b0;
`ifdef CAR_WIPE_SAT_EN
      sat_i_q  <= 1'b0;
      sat_q_q  <= 1'b0;
      tx_sat_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      acc_i_q  <= acc_i_d;
      acc_q_q  <= acc_q_d;
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      tx_i_q   <= tx_i_d;
      tx_q_q   <= tx_q_d;
      tx_vld_q <= tx_vld_d;
`ifdef CAR_WIPE_SAT_EN
      sat_i_q  <= sat_i_d;
      sat_q_q  <= sat_q_d;
      tx_sat_q <= tx_sat_d;
`endif
    end
  end

  assign tx_i_acc    = tx_i_q;
  assign tx_q_acc    = tx_q_q;
  assign tx_dump_vld = tx_vld_q;
`ifdef CAR_WIPE_SAT_EN
  assign tx_sat_flag = tx_sat_q;
`endif

endmodule

// File: tb/tb_car_wipe_acc.sv
// Scoreboard bench for car_wipe_acc (12-bit accumulators so wrap/saturation is reachable).
module tb_car_wipe_acc;

  localparam int CW = 8;
  localparam int IW = 4;
  localparam int AW = 12;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst, en, vld;
  logic [DW-1:0] len;
  logic [IW-1:0] ifs;
  logic [CW-1:0] cs, sn;
  logic [AW-1:0] ti, tq;
  logic          tv;
`ifdef CAR_WIPE_SAT_EN
  logic          ts;
`endif

  always #5 clk = ~clk;

  car_wipe_acc #(.CAR_WIDTH(CW), .IF_WIDTH(IW), .ACC_OUT_WIDTH(AW), .DUMP_CNT_WIDTH(DW)) dut (
    .rx_clk(clk), .rx_rst(rst), .rx_en(en), .rx_dump_len(len), .rx_if(ifs),
    .rx_if_vld(vld), .rx_car_cos(cs), .rx_car_sin(sn),
    .tx_i_acc(ti), .tx_q_acc(tq),
`ifdef CAR_WIPE_SAT_EN
    .tx_sat_flag(ts),
`endif
    .tx_dump_vld(tv)
  );

  typedef struct {
    int i;
    int q;
    bit sat;
    int cyc;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_vec = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   last_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every dump pulse pops one expectation.
  always @(negedge clk) begin
    if (tv) begin
      if (sb.size() == 0) begin
        check("unexpected_dump", 1, 0);
      end else begin
        e = sb.pop_front();
        check("i_acc", int'($signed(ti)), e.i);
        check("q_acc", int'($signed(tq)), e.q);
        check("dump_latency", cyc, e.cyc);
`ifdef CAR_WIPE_SAT_EN
        check("sat_flag", int'(ts), int'(e.sat));
`endif
      end
    end
  end

  task automatic send(input int a, input int c, input int s);
    @(posedge clk); #1;
    vld = 1'b1; ifs = IW'(a); cs = CW'(c); sn = CW'(s);
    last_cyc = cyc;
  endtask

  task automatic gap();
    @(posedge clk); #1;
    vld = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      vld = 1'b0; en = 1'b0;
    end
  endtask

  task automatic begin_period(input int l);
    @(posedge clk); #1;
    len = DW'(l); en = 1'b1; vld = 1'b0;
  endtask

  task automatic expect_dump(input int i, input int q, input bit sat);
    exp_t x;
    x.i = i; x.q = q; x.sat = sat; x.cyc = last_cyc + 2;
    sb.push_back(x);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; vld = 1'b0; len = '0; ifs = '0; cs = '0; sn = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_i_acc", int'($signed(ti)), 0);
    check("rst_q_acc", int'($signed(tq)), 0);
    check("rst_dump_vld", int'(tv), 0);
    rst = 1'b0;

    // basic I-channel period
    begin_period(4);
    repeat (4) send(3, 100, 0);
    expect_dump(1200, 0, 1'b0);
    gap(); idle(3);

    // Q channel with an invalid cycle inside the period
    begin_period(2);
    send(-2, 0, 50); gap(); send(-2, 0, 50);
    expect_dump(0, 200, 1'b0);
    gap(); idle(3);

    // mid-period length change only takes effect at the boundary
    begin_period(3);
    send(1, 10, 0);
    len = DW'(5);
    send(1, 20, 0); send(1, 30, 0);
    expect_dump(60, 0, 1'b0);
    for (int k = 1; k <= 5; k++) send(1, k, 0);
    expect_dump(15, 0, 1'b0);
    gap(); idle(3);

    // accumulator overflow: wrap or clamp
    begin_period(3);
    repeat (3) send(-8, -128, 0);
`ifdef CAR_WIPE_SAT_EN
    expect_dump(2047, 0, 1'b1);
`else
    expect_dump(-1024, 0, 1'b0);
`endif
    gap(); idle(3);

    // back-to-back periods with no lost sample
    begin_period(2);
    send(1, 1, 0); send(1, 2, 0);
    expect_dump(3, 0, 1'b0);
    send(1, 3, 0); send(1, 4, 0);
    expect_dump(7, 0, 1'b0);
    gap(); idle(3);

    // length 0 behaves as 1; both channels at once
    begin_period(0);
    send(2, 3, 4);
    expect_dump(6, -8, 1'b0);
    send(1, 5, 0);
    expect_dump(5, 0, 1'b0);
    gap(); idle(3);

    // reset mid-period: no dump, outputs cleared
    begin_period(4);
    send(3, 100, 0); send(3, 100, 0);
    @(posedge clk); #1;
    rst = 1'b1; en = 1'b0; vld = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_i_acc", int'($signed(ti)), 0);
    check("mid_rst_q_acc", int'($signed(tq)), 0);
    idle(4);

    // rx_en drop discards the partial period; fresh period afterwards
    begin_period(4);
    send(3, 100, 0); send(3, 100, 0);
    idle(2);
    check("en_drop_hold_i", int'($signed(ti)), 0);
    begin_period(4);
    repeat (4) send(3, 100, 0);
    expect_dump(1200, 0, 1'b0);
    gap(); idle(3);

    repeat (20) begin
      if (sb.size() != 0) @(posedge clk);
    end
    check("scoreboard_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
